reader_com_mem: RTL and testbench

- Read side of the command register memory, which holds 256 slots of 338-bit command records.
- Continuously scans the slots and finds records whose TIME_START has been reached by system time.
- For each such record: unpacks the fields, presents them to the synthesizer sequencer over a valid/ready handshake, then invalidates the slot so the writer can reuse it.
- Empty slots are marked by TIME_START = 64'hFFFF_FFFF_FFFF_FFFF.

---
 rtl/reader_com_mem_if.sv | 39 +++
 rtl/reader_com_mem.sv | 119 +++++++++++
 tb/tb_reader_com_mem.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reader_com_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : reader_com_mem_if
// Purpose  : Command hand-off bundle from the command-memory reader to the
//            synthesizer sequencer (valid/ready plus unpacked record fields).
// Revision : 1.0 - initial release
// ============================================================================
interface reader_com_mem_if #(
  parameter int AW = 8
);
  logic          out_valid;
  logic          out_ready;
  logic [47:0]   FREQ;
  logic [47:0]   FREQ_STEP;
  logic [31:0]   FREQ_RATE;
  logic [63:0]   TIME_START;
  logic [15:0]   N_impulse;
  logic [1:0]    TYPE_impulse;
  logic [31:0]   Interval_Ti;
  logic [31:0]   Interval_Tp;
  logic [31:0]   Tblank1;
  logic [31:0]   Tblank2;
  logic [AW-1:0] slot_idx;

  // Reader side: drives the command, receives the accept
  modport master (
    output out_valid, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse,
           TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2, slot_idx,
    input  out_ready
  );

  // Sequencer side: consumes the command, returns the accept
  modport slave (
    input  out_valid, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse,
           TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2, slot_idx,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/reader_com_mem.sv
`default_nettype none
// ============================================================================
// Module   : reader_com_mem
// Purpose  : Scans the command register memory slot by slot, presents every
//            record whose start time has been reached, then invalidates it.
// Revision : 1.0 - initial release
// ============================================================================
module reader_com_mem #(
  parameter int N_IDX  = 256,
  parameter int AW     = 8,
  parameter int DW     = 338,
  parameter int RD_LAT = 2
) (
  input  wire logic          CLK,
  input  wire logic          rst,
  input  wire logic          EN,
  input  wire logic [63:0]   TIME_NOW,
  output logic      [AW-1:0] rd_addr,
  output logic               rd_en,
  input  wire logic [DW-1:0] rd_q,
  output logic      [AW-1:0] clr_addr,
  output logic               clr_wr,
  output logic      [DW-1:0] clr_data,
  output logic               busy,
  reader_com_mem_if.master   cmd
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;
  localparam logic [2:0] CLEAR = 3'd5;
  localparam logic [2:0] NEXT  = 3'd6;

  // WAIT covers RD_LAT-1 cycles so that CHECK lands on the first valid rd_q
  localparam int            WAIT_CYC  = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam int            CW        = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);
  localparam logic [63:0]   EMPTY_T   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic [2:0]    state;
  logic [AW-1:0] ptr;
  logic [CW-1:0] wait_cnt;
  logic [63:0]   rec_time;
  logic          due;

  // Empty slots carry an all-ones start time; a late record is still due
  assign rec_time = rd_q[DW-1:DW-64];
  assign due      = (rec_time != EMPTY_T) && (rec_time <= TIME_NOW);

  assign rd_addr       = ptr;
  assign rd_en         = (state == READ);
  assign clr_addr      = cmd.slot_idx;
  assign clr_wr        = (state == CLEAR);
  assign clr_data      = {EMPTY_T, {(DW-64){1'b0}}};
  assign busy          = (state != IDLE);
  assign cmd.out_valid = (state == EMIT);

  // Scan sequencer: one slot in flight, pointer advances only in NEXT
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE:  if (EN) state <= READ;
        READ: begin
          wait_cnt <= '0;
          state    <= (RD_LAT > 1) ? WAIT : CHECK;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= CHECK;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        CHECK: state <= due ? EMIT : NEXT;
        EMIT:  if (cmd.out_ready) state <= CLEAR;
        CLEAR: state <= NEXT;
        NEXT: begin
          ptr   <= (ptr == AW'(N_IDX - 1)) ? '0 : ptr + 1'b1;
          state <= EN ? READ : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Field capture: loaded only when a due record is found, frozen through EMIT
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cmd.TIME_START   <= '0;
      cmd.FREQ         <= '0;
      cmd.FREQ_STEP    <= '0;
      cmd.FREQ_RATE    <= '0;
      cmd.N_impulse    <= '0;
      cmd.TYPE_impulse <= '0;
      cmd.Interval_Ti  <= '0;
      cmd.Interval_Tp  <= '0;
      cmd.Tblank1      <= '0;
      cmd.Tblank2      <= '0;
      cmd.slot_idx     <= '0;
    end else if (state == CHECK && due) begin
      cmd.TIME_START   <= rd_q[337:274];
      cmd.FREQ         <= rd_q[273:226];
      cmd.FREQ_STEP    <= rd_q[225:178];
      cmd.FREQ_RATE    <= rd_q[177:146];
      cmd.N_impulse    <= rd_q[145:130];
      cmd.TYPE_impulse <= rd_q[129:128];
      cmd.Interval_Ti  <= rd_q[127:96];
      cmd.Interval_Tp  <= rd_q[95:64];
      cmd.Tblank1      <= rd_q[63:32];
      cmd.Tblank2      <= rd_q[31:0];
      cmd.slot_idx     <= ptr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reader_com_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_reader_com_mem
// Purpose  : Self-checking bench for reader_com_mem with a RAM model, a
//            record-level reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reader_com_mem;
  localparam int N_IDX  = 256;
  localparam int AW     = 8;
  localparam int DW     = 338;
  localparam int RD_LAT = 2;
  localparam logic [63:0]   EMPTY_T   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] EMPTY_REC = {EMPTY_T, 274'h0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          EN  = 1'b0;
  logic [63:0]   TIME_NOW = '0;
  logic [AW-1:0] rd_addr, clr_addr;
  logic          rd_en, clr_wr, busy;
  logic [DW-1:0] rd_q = '0;
  logic [DW-1:0] clr_data;

  reader_com_mem_if #(.AW(AW)) cmd();

  always #5 clk = ~clk;

  reader_com_mem #(.N_IDX(N_IDX), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .CLK(clk), .rst(rst), .EN(EN), .TIME_NOW(TIME_NOW),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_q(rd_q),
    .clr_addr(clr_addr), .clr_wr(clr_wr), .clr_data(clr_data),
    .busy(busy), .cmd(cmd)
  );

  // Registered RAM with two-cycle read latency; clear writes win over bench loads
  logic [DW-1:0] ram [N_IDX];
  logic [DW-1:0] s1 = '0;
  logic          tb_fill = 1'b0, tb_wr = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_data = '0;
  always @(posedge clk) begin
    if (tb_fill) begin
      for (int i = 0; i < N_IDX; i++) ram[i] <= EMPTY_REC;
    end else if (clr_wr) ram[clr_addr] <= clr_data;
    else if (tb_wr) ram[tb_addr] <= tb_data;
    if (rd_en) s1 <= ram[rd_addr];
    rd_q <= s1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] ref_mem [N_IDX];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_rec(input logic [63:0] t, input logic [47:0] f,
      input logic [47:0] fs, input logic [31:0] fr, input logic [15:0] n, input logic [1:0] ty,
      input logic [31:0] ti, input logic [31:0] tp, input logic [31:0] b1, input logic [31:0] b2);
    return {t, f, fs, fr, n, ty, ti, tp, b1, b2};
  endfunction

  // Reference model: tracks scan order and decides due-ness from the record table
  initial begin : model
    int            pend;
    logic [AW-1:0] mptr, paddr, eslot;
    bit            emit, clr, clr_n;
    logic [DW-1:0] erec;
    logic [63:0]   t;
    pend = -1; mptr = '0; paddr = '0; eslot = '0; emit = 0; clr = 0; erec = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", cmd.out_valid, 0);
        chk("rst_clr_wr", clr_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_slot_idx", cmd.slot_idx, 0);
        chk("rst_freq", cmd.FREQ, 0);
        chk("rst_time_start", cmd.TIME_START, 0);
        pend = -1; mptr = '0; emit = 0; clr = 0;
      end else begin
        clr_n = 0;
        if (emit) begin
          chk("m_out_valid", cmd.out_valid, 1);
          chk("m_time_start", cmd.TIME_START, erec[337:274]);
          chk("m_freq", cmd.FREQ, erec[273:226]);
          chk("m_freq_step", cmd.FREQ_STEP, erec[225:178]);
          chk("m_freq_rate", cmd.FREQ_RATE, erec[177:146]);
          chk("m_n_impulse", cmd.N_impulse, erec[145:130]);
          chk("m_type", cmd.TYPE_impulse, erec[129:128]);
          chk("m_ti", cmd.Interval_Ti, erec[127:96]);
          chk("m_tp", cmd.Interval_Tp, erec[95:64]);
          chk("m_tblank1", cmd.Tblank1, erec[63:32]);
          chk("m_tblank2", cmd.Tblank2, erec[31:0]);
          chk("m_slot_idx", cmd.slot_idx, eslot);
          if (cmd.out_ready) begin emit = 0; clr_n = 1; end
        end else chk("m_out_valid_idle", cmd.out_valid, 0);
        if (clr) begin
          chk("m_clr_wr", clr_wr, 1);
          chk("m_clr_addr", clr_addr, eslot);
          chk("m_clr_data", clr_data, EMPTY_REC);
          ref_mem[eslot] = EMPTY_REC;
        end else chk("m_clr_wr_idle", clr_wr, 0);
        clr = clr_n;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            t = ref_mem[paddr][337:274];
            if (t != EMPTY_T && t <= TIME_NOW) begin
              emit = 1; erec = ref_mem[paddr]; eslot = paddr;
            end
            pend = -1;
          end
        end
        if (rd_en) begin
          chk("m_one_in_flight", (pend < 0 && !emit && !clr), 1);
          chk("m_rd_addr", rd_addr, mptr);
          paddr = mptr;
          pend  = RD_LAT;
          mptr  = (mptr == AW'(N_IDX - 1)) ? '0 : mptr + 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic restart();
    rst = 1; EN = 0; cmd.out_ready = 0;
    tb_fill = 1; tick(); tb_fill = 0;
    for (int i = 0; i < N_IDX; i++) ref_mem[i] = EMPTY_REC;
  endtask

  task automatic load(input int slot, input logic [DW-1:0] rec);
    tb_addr = AW'(slot); tb_data = rec; tb_wr = 1; tick(); tb_wr = 0;
    ref_mem[slot] = rec;
  endtask

  task automatic release_run();
    tick(); rst = 0; EN = 1;
  endtask

  task automatic wait_rd(input int budget, output logic [AW-1:0] a, output int c, output bit ok);
    ok = 0; a = '0; c = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (rd_en) begin a = rd_addr; c = cyc; ok = 1; end
    end
    if (!ok) chk("timeout_rd_en", 0, 1);
  endtask

  task automatic wait_valid(input int budget, output int c, output bit ok);
    ok = 0; c = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cmd.out_valid) begin c = cyc; ok = 1; end
    end
    if (!ok) chk("timeout_out_valid", 0, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [AW-1:0] a;
    logic [AW-1:0] addrs [2];
    int c, prev_c, c6, got, cnt;
    bit ok;
    cmd.out_ready = 0;

    // Reset state, then an all-empty sweep with wrap
    restart();
    @(negedge clk);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", cmd.out_valid, 0);
    release_run();
    prev_c = 0;
    for (int i = 0; i <= N_IDX; i++) begin
      wait_rd(20, a, c, ok);
      if (!ok) break;
      chk("sweep_addr", a, i % N_IDX);
      if (i > 0) chk("sweep_gap", c - prev_c, RD_LAT + 2);
      prev_c = c;
    end

    // Slot 5 not yet due, becomes due once time reaches 1000
    restart();
    load(5, mk_rec(64'd1000, 48'h123456789ABC, 48'h1, 32'h2, 16'd10, 2'd2,
                   32'h11, 32'h22, 32'h33, 32'h44));
    TIME_NOW = 64'd999; cmd.out_ready = 1;
    release_run();
    c6 = 0;
    for (int k = 0; k < 10; k++) begin
      wait_rd(20, a, c6, ok);
      if (!ok || a == 6) break;
    end
    tick(); TIME_NOW = 64'd1000;
    wait_valid(1200, c, ok);
    chk("s5_not_first_pass", (c - c6) > 200 * (RD_LAT + 2), 1);
    chk("s5_freq", cmd.FREQ, 48'h123456789ABC);
    chk("s5_n_impulse", cmd.N_impulse, 16'd10);
    chk("s5_type", cmd.TYPE_impulse, 2'd2);
    chk("s5_slot_idx", cmd.slot_idx, 5);
    chk("s5_tblank2", cmd.Tblank2, 32'h44);
    @(negedge clk);
    chk("s5_clr_wr", clr_wr, 1);
    chk("s5_clr_addr", clr_addr, 5);
    chk("s5_clr_data_hi", clr_data[337:274], EMPTY_T);
    chk("s5_valid_dropped", cmd.out_valid, 0);

    // Back-pressure: fields hold for 20 cycles while time advances
    restart();
    load(2, mk_rec(64'd50, 48'hA5A5_5A5A_0F0F, 48'h7, 32'h9, 16'd3, 2'd1,
                   32'h100, 32'h200, 32'h300, 32'h400));
    TIME_NOW = 64'd100; cmd.out_ready = 0;
    release_run();
    wait_valid(100, c, ok);
    for (int i = 0; i < 20; i++) begin
      tick(); TIME_NOW = TIME_NOW + 64'd7;
      @(negedge clk);
      chk("hold_valid", cmd.out_valid, 1);
      chk("hold_freq", cmd.FREQ, 48'hA5A5_5A5A_0F0F);
      chk("hold_time_start", cmd.TIME_START, 64'd50);
      chk("hold_no_clr", clr_wr, 0);
    end
    tick(); cmd.out_ready = 1;
    @(negedge clk);
    chk("hold_accept_valid", cmd.out_valid, 1);
    tick(); cmd.out_ready = 0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (clr_wr) cnt++;
    end
    chk("hold_clr_count", cnt, 1);

    // Two due slots are emitted in scan order
    restart();
    load(3,   mk_rec(64'd20, 48'h3, 48'h0, 32'h0, 16'd1, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0));
    load(200, mk_rec(64'd10, 48'hC8, 48'h0, 32'h0, 16'd2, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0));
    TIME_NOW = 64'd100; cmd.out_ready = 1;
    release_run();
    got = 0; addrs[0] = '0; addrs[1] = '0;
    for (int i = 0; i < 1200 && got < 2; i++) begin
      @(negedge clk);
      if (clr_wr) begin addrs[got] = clr_addr; got++; end
    end
    chk("order_count", got, 2);
    chk("order_first", addrs[0], 3);
    chk("order_second", addrs[1], 200);
    wait_rd(20, a, c, ok);
    chk("order_next_ptr", a, 201);

    // Asynchronous reset during EMIT discards the clear
    restart();
    load(7, mk_rec(64'd5, 48'h777, 48'h0, 32'h0, 16'd7, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0));
    TIME_NOW = 64'd10; cmd.out_ready = 0;
    release_run();
    wait_valid(100, c, ok);
    tick(); rst = 1;
    #1;
    chk("async_valid", cmd.out_valid, 0);
    chk("async_freq", cmd.FREQ, 0);
    chk("async_slot", cmd.slot_idx, 0);
    chk("async_busy", busy, 0);
    chk("async_clr_wr", clr_wr, 0);
    tick(); tick();
    cmd.out_ready = 1;
    release_run();
    wait_valid(100, c, ok);
    chk("reemit_slot", cmd.slot_idx, 7);
    chk("reemit_freq", cmd.FREQ, 48'h777);
    @(negedge clk);
    chk("reemit_clr_addr", clr_addr, 7);

    // EN dropped during WAIT for slot 10: finish the slot, idle at 11
    restart();
    release_run();
    for (int k = 0; k < 15; k++) begin
      wait_rd(20, a, c, ok);
      if (!ok || a == 10) break;
    end
    tick(); EN = 0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    chk("en_idle_reached", ok, 1);
    chk("en_idle_ptr", rd_addr, 11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("en_idle_no_read", rd_en, 0);
    end
    tick(); EN = 1;
    wait_rd(10, a, c, ok);
    chk("en_resume_addr", a, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
